// File: rtl/dmem_mmio_pkg.sv
// Shared definitions for the data-side memory/MMIO responder.
// Holds the MMIO decode constants, the TXSTAT bit layout and the serializer state type.
package dmem_mmio_pkg;

    localparam logic [31:0] MMIO_BASE = 32'h8000_0000;

    localparam logic [2:0] REG_CYCLE  = 3'd0;
    localparam logic [2:0] REG_LED    = 3'd1;
    localparam logic [2:0] REG_TXDATA = 3'd2;
    localparam logic [2:0] REG_TXSTAT = 3'd3;

    localparam int unsigned STAT_BUSY     = 0;
    localparam int unsigned STAT_EMPTY    = 1;
    localparam int unsigned STAT_FULL     = 2;
    localparam int unsigned STAT_OVERFLOW = 3;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_STOP
    } tx_state_t;

endpackage

// File: rtl/dmem_mmio_uart_tx_fifo.sv
// Byte FIFO feeding an 8N1 serial transmitter, with a sticky overflow flag.
// The transmitter pops the FIFO head from IDLE and emits start, 8 data bits LSB first, stop.
module uart_tx_fifo
    import dmem_mmio_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned CLK_DIV    = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       push,
    input  logic [7:0] push_data,
    input  logic       clr_overflow,
    output logic       busy,
    output logic       empty,
    output logic       full,
    output logic       overflow,
    output logic       uart_tx
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned DW = $clog2(CLK_DIV);
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

    logic [7:0]    fifo_mem [FIFO_DEPTH];
    logic [AW:0]   wr_ptr;
    logic [AW:0]   rd_ptr;
    logic [7:0]    shift_reg;
    logic [DW-1:0] div_cnt;
    logic [2:0]    bit_cnt;
    tx_state_t     state;
    logic          push_ok;
    logic          pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop     = (state == TX_IDLE) && !empty;
    // A push while full is dropped even when a pop frees a slot on the same edge.
    assign push_ok = push && !full;
    assign busy    = (state != TX_IDLE);

    always_ff @(posedge clk) begin
        if (push_ok) fifo_mem[wr_ptr[AW-1:0]] <= push_data;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            overflow <= 1'b0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (pop)     rd_ptr <= rd_ptr + (AW+1)'(1);
            if (push && full)      overflow <= 1'b1;
            else if (clr_overflow) overflow <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= TX_IDLE;
            uart_tx   <= 1'b1;
            shift_reg <= '0;
            div_cnt   <= '0;
            bit_cnt   <= '0;
        end else begin
            case (state)
                TX_IDLE: begin
                    if (!empty) begin
                        shift_reg <= fifo_mem[rd_ptr[AW-1:0]];
                        div_cnt   <= '0;
                        bit_cnt   <= '0;
                        uart_tx   <= 1'b0;
                        state     <= TX_START;
                    end
                end
                TX_START: begin
                    if (div_cnt == DIV_LAST) begin
                        div_cnt <= '0;
                        uart_tx <= shift_reg[0];
                        state   <= TX_DATA;
                    end else begin
                        div_cnt <= div_cnt + DW'(1);
                    end
                end
                TX_DATA: begin
                    if (div_cnt == DIV_LAST) begin
                        div_cnt <= '0;
                        if (bit_cnt == 3'd7) begin
                            uart_tx <= 1'b1;
                            state   <= TX_STOP;
                        end else begin
                            bit_cnt   <= bit_cnt + 3'd1;
                            shift_reg <= {1'b0, shift_reg[7:1]};
                            uart_tx   <= shift_reg[1];
                        end
                    end else begin
                        div_cnt <= div_cnt + DW'(1);
                    end
                end
                TX_STOP: begin
                    if (div_cnt == DIV_LAST) begin
                        div_cnt <= '0;
                        state   <= TX_IDLE;
                    end else begin
                        div_cnt <= div_cnt + DW'(1);
                    end
                end
                default: state <= TX_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/dmem_mmio.sv
// Data-side responder for the RV32 core: word RAM plus an MMIO window holding
// a cycle counter, an LED register and the UART transmit path. Read data is registered.
module dmem_mmio
    import dmem_mmio_pkg::*;
#(
    parameter int unsigned RAM_WORDS  = 1024,
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned CLK_DIV    = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic        mem_write,
    output logic [31:0] mem_rdata,
    output logic [7:0]  led,
    output logic        uart_tx
);

    localparam int unsigned RAW = $clog2(RAM_WORDS);

    logic [31:0]    ram [RAM_WORDS];
    logic [31:0]    cycle_cnt;
    logic [RAW-1:0] ram_idx;
    logic           is_mmio;
    logic [2:0]     reg_sel;
    logic [31:0]    rd_val;
    logic           wr_ram;
    logic           wr_led;
    logic           tx_push;
    logic           tx_clr;
    logic           tx_busy;
    logic           tx_empty;
    logic           tx_full;
    logic           tx_overflow;
    logic           unused_addr;

    assign ram_idx     = mem_addr[RAW+1:2];
    assign is_mmio     = (mem_addr[31] == MMIO_BASE[31]);
    assign reg_sel     = mem_addr[4:2];
    assign unused_addr = ^{mem_addr[30:RAW+2], mem_addr[1:0]};

    assign wr_ram  = mem_write && !is_mmio;
    assign wr_led  = mem_write && is_mmio && (reg_sel == REG_LED);
    assign tx_push = mem_write && is_mmio && (reg_sel == REG_TXDATA);
    assign tx_clr  = mem_write && is_mmio && (reg_sel == REG_TXSTAT) && mem_wdata[STAT_OVERFLOW];

    always_ff @(posedge clk) begin
        if (wr_ram) ram[ram_idx] <= mem_wdata;
    end

    // RAM read uses the pre-edge array contents, giving read-first behaviour.
    always_comb begin
        rd_val = '0;
        if (!is_mmio) begin
            rd_val = ram[ram_idx];
        end else begin
            case (reg_sel)
                REG_CYCLE: rd_val = cycle_cnt;
                REG_LED:   rd_val = {24'b0, led};
                REG_TXSTAT: begin
                    rd_val[STAT_BUSY]     = tx_busy;
                    rd_val[STAT_EMPTY]    = tx_empty;
                    rd_val[STAT_FULL]     = tx_full;
                    rd_val[STAT_OVERFLOW] = tx_overflow;
                end
                default:   rd_val = '0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mem_rdata <= '0;
            led       <= '0;
            cycle_cnt <= '0;
        end else begin
            mem_rdata <= rd_val;
            cycle_cnt <= cycle_cnt + 32'd1;
            if (wr_led) led <= mem_wdata[7:0];
        end
    end

    uart_tx_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH),
        .CLK_DIV    (CLK_DIV)
    ) u_tx (
        .clk          (clk),
        .reset        (reset),
        .push         (tx_push),
        .push_data    (mem_wdata[7:0]),
        .clr_overflow (tx_clr),
        .busy         (tx_busy),
        .empty        (tx_empty),
        .full         (tx_full),
        .overflow     (tx_overflow),
        .uart_tx      (uart_tx)
    );

endmodule

// File: tb/tb_dmem_mmio.sv
// Scoreboard bench for dmem_mmio: stimulus pushes expected responses from a
// behavioural model; a monitor pops and compares one cycle after each issued access.
module tb_dmem_mmio;

    localparam int unsigned RAM_WORDS  = 1024;
    localparam int unsigned FIFO_DEPTH = 8;
    localparam int unsigned CLK_DIV    = 4;
    localparam logic [31:0] MMIO       = 32'h8000_0000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] mem_addr = '0;
    logic [31:0] mem_wdata = '0;
    logic        mem_write = 1'b0;
    logic [31:0] mem_rdata;
    logic [7:0]  led;
    logic        uart_tx;

    always #5 clk = ~clk;

    dmem_mmio #(
        .RAM_WORDS  (RAM_WORDS),
        .FIFO_DEPTH (FIFO_DEPTH),
        .CLK_DIV    (CLK_DIV)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_write (mem_write),
        .mem_rdata (mem_rdata),
        .led       (led),
        .uart_tx   (uart_tx)
    );

    typedef struct {
        logic [31:0] rdata;
        bit          rchk;
        logic [7:0]  led;
        logic        tx;
        bit          tchk;
    } exp_t;

    exp_t        sb[$];
    string       nm_q[$];
    int unsigned passed = 0;
    int unsigned total  = 0;

    logic [31:0] ram_m [int unsigned];
    logic [7:0]  led_m = '0;
    logic [31:0] cyc_m = '0;

    // Cycle counter reference: number of clock edges since reset released.
    always @(posedge clk) cyc_m <= reset ? 32'd0 : cyc_m + 32'd1;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    initial begin
        exp_t  e;
        string n;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                n = nm_q.pop_front();
                if (e.rchk) check({n, ".rdata"}, mem_rdata, e.rdata);
                check({n, ".led"}, {24'h0, led}, {24'h0, e.led});
                if (e.tchk) check({n, ".uart_tx"}, {31'h0, uart_tx}, {31'h0, e.tx});
            end
        end
    end

    task automatic issue(input logic [31:0] a, input logic [31:0] wd, input logic we,
                         input string nm, input logic rst = 1'b0,
                         input bit ov_en = 1'b0, input logic [31:0] ov_val = '0,
                         input bit tx_en = 1'b0, input logic tx_val = 1'b1);
        exp_t        e;
        int unsigned idx;
        int unsigned sel;
        @(negedge clk);
        reset     = rst;
        mem_addr  = a;
        mem_wdata = wd;
        mem_write = we;
        idx = (a >> 2) % RAM_WORDS;
        sel = (a >> 2) % 8;
        e.rchk = 1'b1;
        e.tchk = tx_en;
        e.tx   = tx_val;
        e.rdata = '0;
        if (rst) begin
            led_m  = '0;
            e.tx   = 1'b1;
            e.tchk = 1'b1;
        end else if (ov_en) begin
            e.rdata = ov_val;
        end else if (a < MMIO) begin
            if (ram_m.exists(idx)) e.rdata = ram_m[idx];
            else e.rchk = 1'b0;
        end else begin
            case (sel)
                0: e.rdata = cyc_m;
                1: e.rdata = {24'h0, led_m};
                3: e.rdata = 32'h2;
                default: e.rdata = '0;
            endcase
        end
        if (we && a < MMIO) ram_m[idx] = wd;
        if (we && !rst && a >= MMIO && sel == 1) led_m = wd[7:0];
        e.led = led_m;
        sb.push_back(e);
        nm_q.push_back(nm);
        @(posedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        logic [7:0]  frame_byte;
        logic [31:0] a;
        logic        txv;
        logic [31:0] st;
        int unsigned r;

        repeat (3) issue(MMIO + 32'h14, 32'h0, 1'b0, "reset", 1'b1);

        // Counter: read at the 5th edge after release must return 4.
        repeat (4) issue(MMIO + 32'h14, 32'h0, 1'b0, "idle");
        issue(MMIO, 32'h0, 1'b0, "cycle5", 1'b0, 1'b1, 32'd4);
        issue(MMIO, 32'h0, 1'b0, "cycle6", 1'b0, 1'b1, 32'd5);

        issue(32'h0000_0010, 32'hDEAD_BEEF, 1'b1, "ram_wr");
        issue(32'h0000_0010, 32'h0, 1'b0, "ram_rd", 1'b0, 1'b1, 32'hDEAD_BEEF);
        issue(32'h0000_1010, 32'h0, 1'b0, "ram_alias", 1'b0, 1'b1, 32'hDEAD_BEEF);

        issue(32'h0000_0020, 32'h1111_1111, 1'b1, "rf_init");
        issue(32'h0000_0020, 32'h2222_2222, 1'b1, "rf_same", 1'b0, 1'b1, 32'h1111_1111);
        issue(32'h0000_0020, 32'h0, 1'b0, "rf_after", 1'b0, 1'b1, 32'h2222_2222);

        issue(MMIO + 32'h4, 32'h1A5, 1'b1, "led_wr");
        issue(MMIO + 32'h4, 32'h0, 1'b0, "led_rd", 1'b0, 1'b1, 32'hA5);
        issue(MMIO + 32'h14, 32'h0, 1'b0, "reg5_rd", 1'b0, 1'b1, 32'h0);
        issue(MMIO, 32'hFFFF_0000, 1'b1, "cyc_wr");
        issue(MMIO, 32'h0, 1'b0, "cyc_after_wr");

        for (int i = 0; i < 300; i++) begin
            r = $urandom_range(0, 9);
            a = $urandom;
            if (r < 5) begin
                a[31]  = 1'b0;
                a[5:2] = 4'($urandom_range(0, 15));
                issue(a, $urandom, 1'($urandom_range(0, 1)), "rand_ram");
            end else begin
                a[31]  = 1'b1;
                a[4:2] = 3'($urandom_range(0, 7));
                issue(a, $urandom, (a[4:2] == 3'd2) ? 1'b0 : 1'($urandom_range(0, 1)), "rand_mmio");
            end
        end

        // Single frame of 0x55: pop on the edge after the push, then 4 cycles per bit.
        frame_byte = 8'h55;
        issue(MMIO + 32'h8, 32'h55, 1'b1, "tx_push", 1'b0, 1'b1, 32'h0, 1'b1, 1'b1);
        for (int i = 1; i <= 44; i++) begin
            if (i == 1) st = 32'h0;
            else if (i <= 41) st = 32'h3;
            else st = 32'h2;
            if (i <= 4) txv = 1'b0;
            else if (i <= 36) txv = frame_byte[(i - 5) / 4];
            else txv = 1'b1;
            issue(MMIO + 32'hC, 32'h0, 1'b0, "tx_frame", 1'b0, 1'b1, st, 1'b1, txv);
        end

        for (int k = 0; k < FIFO_DEPTH + 2; k++)
            issue(MMIO + 32'h8, 32'hA0 + k, 1'b1, "ovf_push");
        issue(MMIO + 32'hC, 32'h0, 1'b0, "ovf_stat", 1'b0, 1'b1, 32'hD);
        issue(MMIO + 32'hC, 32'h8, 1'b1, "ovf_clr", 1'b0, 1'b1, 32'hD);
        issue(MMIO + 32'hC, 32'h0, 1'b0, "ovf_after", 1'b0, 1'b1, 32'h5);

        issue(MMIO + 32'hC, 32'h0, 1'b0, "rst_mid", 1'b1);
        issue(MMIO + 32'hC, 32'h0, 1'b0, "rst_stat", 1'b0, 1'b1, 32'h2, 1'b1, 1'b1);
        repeat (6) issue(MMIO + 32'hC, 32'h0, 1'b0, "rst_idle", 1'b0, 1'b1, 32'h2, 1'b1, 1'b1);

        @(negedge clk);
        mem_write = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        total++;
        if (sb.size() == 0) passed++;
        else $display("FAIL drain: got %0d pending expected 0", sb.size());

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
